ff_response_checker: RTL and testbench

//  Synthesizable checker for the receive end of flip-flop stimulus: samples the s/r/rst

---
 rtl/ff_response_checker.sv | 113 +++++++++++
 tb/tb_ff_response_checker.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/ff_response_checker.sv
// ff_response_checker: cycle-exact reference model of an SR/JK/D/T flip-flop that
// checks a DUT's q/q_bar against the drive it received and keeps error statistics.
module ff_response_checker #(
  parameter int FF_TYPE   = 0,
  parameter int CNT_W     = 8,
  parameter bit STOP_FAIL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             s,
  input  logic             r,
  input  logic             dut_rst,
  input  logic             q,
  input  logic             q_bar,
  output logic             checking,
  output logic             err,
  output logic             comp_err,
  output logic             illegal,
  output logic             err_sticky,
  output logic [CNT_W-1:0] chk_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] first_fail
);
  typedef enum logic [1:0] {IDLE, SYNC, CHECK, FAIL} state_t;
  localparam logic [CNT_W-1:0] ONES = '1;
  state_t state_q, state_d;
  logic m_q, m_d, mv_q, mv_d;
  logic err_q, err_d, ce_q, ce_d, ill_q, ill_d, sticky_q, sticky_d;
  logic [CNT_W-1:0] chk_q, chk_d, ecnt_q, ecnt_d, ff_q, ff_d;
  logic cmp, mis, cex;
  logic [CNT_W:0] esum;
  always_comb begin
    m_d   = m_q;
    mv_d  = mv_q;
    ill_d = 1'b0;
    if (dut_rst) begin
      m_d  = 1'b0;
      mv_d = 1'b1;
    end else if (FF_TYPE == 0) begin
      if (s & r) begin
        mv_d  = 1'b0;
        ill_d = 1'b1;
      end else if (s | r) begin
        m_d  = s;
        mv_d = 1'b1;
      end
    end else if (FF_TYPE == 1) begin
      if (s & r) m_d = ~m_q;
      else if (s | r) begin
        m_d  = s;
        mv_d = 1'b1;
      end
    end else if (FF_TYPE == 2) begin
      m_d  = s;
      mv_d = 1'b1;
    end else if (s) m_d = ~m_q;
  end
  // Compares use pre-edge q against the pre-edge model value (one-cycle DUT latency).
  always_comb begin
    cmp      = (state_q == CHECK) && mv_q;
    mis      = cmp && (q != m_q);
    cex      = (state_q == CHECK) && (q_bar == q);
    esum     = {1'b0, ecnt_q} + (CNT_W+1)'(mis) + (CNT_W+1)'(cex);
    chk_d    = clr ? '0 : (cmp && chk_q != ONES) ? chk_q + CNT_W'(1) : chk_q;
    ecnt_d   = clr ? '0 : (esum > {1'b0, ONES}) ? ONES : esum[CNT_W-1:0];
    ff_d     = clr ? ONES : (!sticky_q && (mis || cex)) ? chk_d : ff_q;
    sticky_d = !clr && (sticky_q || mis || cex);
    err_d    = !clr && mis;
    ce_d     = !clr && cex;
    state_d  = clr ? IDLE :
               (state_q == FAIL) ? FAIL :
               !en ? IDLE :
               (state_q == IDLE) ? SYNC :
               (state_q == SYNC) ? (mv_d ? CHECK : SYNC) :
               (mis && STOP_FAIL) ? FAIL :
               mv_d ? CHECK : SYNC;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      m_q      <= 1'b0;
      mv_q     <= 1'b0;
      err_q    <= 1'b0;
      ce_q     <= 1'b0;
      ill_q    <= 1'b0;
      sticky_q <= 1'b0;
      chk_q    <= '0;
      ecnt_q   <= '0;
      ff_q     <= ONES;
    end else begin
      state_q  <= state_d;
      m_q      <= m_d;
      mv_q     <= mv_d;
      err_q    <= err_d;
      ce_q     <= ce_d;
      ill_q    <= ill_d;
      sticky_q <= sticky_d;
      chk_q    <= chk_d;
      ecnt_q   <= ecnt_d;
      ff_q     <= ff_d;
    end
  end
  assign checking   = (state_q == CHECK);
  assign err        = err_q;
  assign comp_err   = ce_q;
  assign illegal    = ill_q;
  assign err_sticky = sticky_q;
  assign chk_cnt    = chk_q;
  assign err_cnt    = ecnt_q;
  assign first_fail = ff_q;
endmodule

// File: tb/tb_ff_response_checker.sv
// tb_ff_response_checker: directed vectors for SR (plain, STOP_FAIL, CNT_W=3) and T checkers.
module tb_ff_response_checker;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0, clr = 1'b0, s = 1'b0, r = 1'b0, dut_rst = 1'b0, q = 1'b0, q_bar = 1'b1;
  logic [3:0] ck, er, ce, il, st;
  logic [7:0] cc[4], ec[4], ff[4];
  logic [2:0] cc2, ec2, ff2;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  ff_response_checker #(.FF_TYPE(0), .CNT_W(8), .STOP_FAIL(1'b0)) u0 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .s(s), .r(r), .dut_rst(dut_rst), .q(q), .q_bar(q_bar),
    .checking(ck[0]), .err(er[0]), .comp_err(ce[0]), .illegal(il[0]), .err_sticky(st[0]),
    .chk_cnt(cc[0]), .err_cnt(ec[0]), .first_fail(ff[0]));
  ff_response_checker #(.FF_TYPE(0), .CNT_W(8), .STOP_FAIL(1'b1)) u1 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .s(s), .r(r), .dut_rst(dut_rst), .q(q), .q_bar(q_bar),
    .checking(ck[1]), .err(er[1]), .comp_err(ce[1]), .illegal(il[1]), .err_sticky(st[1]),
    .chk_cnt(cc[1]), .err_cnt(ec[1]), .first_fail(ff[1]));
  ff_response_checker #(.FF_TYPE(0), .CNT_W(3), .STOP_FAIL(1'b0)) u2 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .s(s), .r(r), .dut_rst(dut_rst), .q(q), .q_bar(q_bar),
    .checking(ck[2]), .err(er[2]), .comp_err(ce[2]), .illegal(il[2]), .err_sticky(st[2]),
    .chk_cnt(cc2), .err_cnt(ec2), .first_fail(ff2));
  ff_response_checker #(.FF_TYPE(3), .CNT_W(8), .STOP_FAIL(1'b0)) u3 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .s(s), .r(r), .dut_rst(dut_rst), .q(q), .q_bar(q_bar),
    .checking(ck[3]), .err(er[3]), .comp_err(ce[3]), .illegal(il[3]), .err_sticky(st[3]),
    .chk_cnt(cc[3]), .err_cnt(ec[3]), .first_fail(ff[3]));
  assign cc[2] = {5'b0, cc2};
  assign ec[2] = {5'b0, ec2};
  assign ff[2] = {5'b0, ff2};
  typedef struct {
    logic e, si, ri, di, qi, qbi;
    logic x_ck, x_er, x_ce, x_il, x_st;
    logic [7:0] x_cc, x_ec, x_ff;
  } vec_t;
  vec_t tbl[15];
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic drive(input logic e, input logic si, input logic ri, input logic di,
                       input logic qi, input logic qbi);
    en = e; s = si; r = ri; dut_rst = di; q = qi; q_bar = qbi;
    @(posedge clk);
    #1;
  endtask
  initial begin
    //          en s r d q qb | ck er ce il st | chk ecnt first_fail
    tbl[0]  = '{1,0,0,1,0,1, 0,0,0,0,0, 8'd0,  8'd0, 8'd255};
    tbl[1]  = '{1,0,0,0,0,1, 1,0,0,0,0, 8'd0,  8'd0, 8'd255};
    tbl[2]  = '{1,1,0,0,0,1, 1,0,0,0,0, 8'd1,  8'd0, 8'd255};
    tbl[3]  = '{1,0,0,0,1,0, 1,0,0,0,0, 8'd2,  8'd0, 8'd255};
    tbl[4]  = '{1,0,1,0,1,0, 1,0,0,0,0, 8'd3,  8'd0, 8'd255};
    tbl[5]  = '{1,0,0,0,0,1, 1,0,0,0,0, 8'd4,  8'd0, 8'd255};
    tbl[6]  = '{1,1,1,0,0,1, 0,0,0,1,0, 8'd5,  8'd0, 8'd255};
    tbl[7]  = '{1,0,0,0,0,1, 0,0,0,0,0, 8'd5,  8'd0, 8'd255};
    tbl[8]  = '{1,1,0,0,0,1, 1,0,0,0,0, 8'd5,  8'd0, 8'd255};
    tbl[9]  = '{1,0,0,0,1,0, 1,0,0,0,0, 8'd6,  8'd0, 8'd255};
    tbl[10] = '{1,0,0,0,0,1, 1,1,0,0,1, 8'd7,  8'd1, 8'd7};
    tbl[11] = '{1,0,0,0,0,1, 1,1,0,0,1, 8'd8,  8'd2, 8'd7};
    tbl[12] = '{1,0,1,0,1,0, 1,0,0,0,1, 8'd9,  8'd2, 8'd7};
    tbl[13] = '{1,0,0,0,0,0, 1,0,1,0,1, 8'd10, 8'd3, 8'd7};
    tbl[14] = '{1,0,0,0,0,1, 1,0,0,0,1, 8'd11, 8'd3, 8'd7};
    repeat (2) @(posedge clk);
    #1;
    check("rst checking", ck[0], 0);
    check("rst chk_cnt", cc[0], 0);
    check("rst err_cnt", ec[0], 0);
    check("rst first_fail", ff[0], 8'd255);
    check("rst sticky", st[0], 0);
    check("rst first_fail w3", ff[2], 8'd7);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].e, tbl[i].si, tbl[i].ri, tbl[i].di, tbl[i].qi, tbl[i].qbi);
      check($sformatf("v%0d checking", i), ck[0], tbl[i].x_ck);
      check($sformatf("v%0d err", i), er[0], tbl[i].x_er);
      check($sformatf("v%0d comp_err", i), ce[0], tbl[i].x_ce);
      check($sformatf("v%0d illegal", i), il[0], tbl[i].x_il);
      check($sformatf("v%0d sticky", i), st[0], tbl[i].x_st);
      check($sformatf("v%0d chk_cnt", i), cc[0], tbl[i].x_cc);
      check($sformatf("v%0d err_cnt", i), ec[0], tbl[i].x_ec);
      check($sformatf("v%0d first_fail", i), ff[0], tbl[i].x_ff);
    end
    check("stopfail checking", ck[1], 0);
    check("stopfail chk frozen", cc[1], 8'd7);
    check("stopfail err_cnt", ec[1], 8'd1);
    check("stopfail first_fail", ff[1], 8'd7);
    clr = 1'b1;
    drive(1, 0, 0, 0, 0, 1);
    clr = 1'b0;
    check("clr checking", ck[0], 0);
    check("clr chk_cnt", cc[0], 0);
    check("clr err_cnt", ec[0], 0);
    check("clr first_fail", ff[0], 8'd255);
    check("clr sticky", st[0], 0);
    check("clr stopfail chk", cc[1], 0);
    check("clr stopfail ff", ff[1], 8'd255);
    drive(1, 0, 0, 0, 0, 1);
    check("resume sync", ck[0], 0);
    drive(1, 0, 0, 0, 0, 1);
    check("resume check", ck[0], 1);
    check("resume stopfail", ck[1], 1);
    check("resume w3", ck[2], 1);
    check("resume chk_cnt", cc[0], 0);
    for (int k = 1; k <= 5; k++) begin
      drive(1, 0, 0, 0, 1, 1);
      check($sformatf("sat%0d err", k), er[2], 1);
      check($sformatf("sat%0d comp_err", k), ce[2], 1);
      check($sformatf("sat%0d err_cnt w3", k), ec[2], (2 * k > 7) ? 8'd7 : 8'(2 * k));
      check($sformatf("sat%0d err_cnt", k), ec[0], 8'(2 * k));
      check($sformatf("sat%0d chk_cnt", k), cc[0], 8'(k));
      if (k == 1) begin
        check("sat first_fail", ff[0], 8'd1);
        check("sat sticky", st[0], 1);
        check("sat stopfail fail", ck[1], 0);
        check("sat stopfail err_cnt", ec[1], 8'd2);
      end
    end
    check("sat stopfail chk", cc[1], 8'd1);
    drive(0, 0, 0, 0, 0, 1);
    check("en0 checking", ck[0], 0);
    check("en0 last chk", cc[0], 8'd6);
    check("en0 err", er[0], 0);
    drive(0, 0, 0, 0, 0, 1);
    check("idle chk held", cc[0], 8'd6);
    check("idle err_cnt held", ec[0], 8'd10);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    drive(1, 0, 0, 1, 0, 1);
    drive(1, 0, 0, 0, 0, 1);
    check("t checking", ck[3], 1);
    for (int k = 0; k < 4; k++) drive(1, 1, 0, 0, k[0], ~k[0]);
    check("t after toggles", ck[3], 1);
    check("t chk_cnt", cc[3], 8'd4);
    check("t err_cnt", ec[3], 0);
    check("t sticky", st[3], 0);
    #3;
    rst = 1'b0;
    #1;
    check("async checking", ck[3], 0);
    check("async chk_cnt", cc[3], 0);
    check("async first_fail", ff[3], 8'd255);
    check("async sr err_cnt", ec[0], 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
